// File: rtl/alu_exec_unit.sv
// EX-stage ALU: aluop/funct decode, single-cycle logic/arith/shift ops and an iterative
// shift-add multiplier, all results leaving through a one-entry valid/ready output register.
module alu_exec_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_STEP = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       aluop_i,
  input  logic [4:0]       funct_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             illegal_o,
  output logic             busy_o
);

  localparam int unsigned K    = WIDTH / MUL_STEP;
  localparam int unsigned CntW = $clog2(K) + 1;
  localparam int unsigned ShW  = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OpAdd, OpSub, OpMul, OpAnd, OpOr, OpXor, OpSll, OpSrl, OpIll
  } op_e;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              zero_q, zero_d;
  logic              illegal_q, illegal_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;

  op_e               op;
  logic [WIDTH-1:0]  alu_res;
  logic              alu_ill;
  logic [WIDTH-1:0]  step_sum;
  logic [ShW-1:0]    shamt;
  logic              accept;

  assign busy_o  = (state_q == StMul);
  assign ready_o = !busy_o && (!valid_q || ready_i);
  assign accept  = valid_i && ready_o;
  assign shamt   = src2_i[ShW-1:0];

  always_comb begin
    op = OpAdd;
    unique case (aluop_i)
      2'b00, 2'b11: op = OpAdd;
      2'b01:        op = OpSub;
      2'b10: begin
        case (funct_i)
          5'b00000: op = OpAdd;
          5'b10000: op = OpSub;
          5'b01000: op = OpMul;
          5'b00111: op = OpAnd;
          5'b00110: op = OpOr;
          5'b00100: op = OpXor;
          5'b00001: op = OpSll;
          5'b00101: op = OpSrl;
          default:  op = OpIll;
        endcase
      end
      default: op = OpAdd;
    endcase
  end

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (op)
      OpAdd:   alu_res = src1_i + src2_i;
      OpSub:   alu_res = src1_i - src2_i;
      OpAnd:   alu_res = src1_i & src2_i;
      OpOr:    alu_res = src1_i | src2_i;
      OpXor:   alu_res = src1_i ^ src2_i;
      OpSll:   alu_res = src1_i << shamt;
      OpSrl:   alu_res = src1_i >> shamt;
      OpIll:   alu_ill = 1'b1;
      default: alu_res = '0;
    endcase
  end

  // One shift-add step: fold MUL_STEP multiplier bits into the accumulator.
  always_comb begin
    step_sum = acc_q;
    for (int unsigned i = 0; i < MUL_STEP; i++) begin
      if (mplier_q[i]) begin
        step_sum = step_sum + (mcand_q << i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;

    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (op == OpMul) begin
            state_d  = StMul;
            acc_d    = '0;
            mcand_d  = src1_i;
            mplier_d = src2_i;
            cnt_d    = CntW'(K);
          end else begin
            valid_d   = 1'b1;
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            illegal_d = alu_ill;
          end
        end
      end
      StMul: begin
        acc_d    = step_sum;
        mcand_d  = mcand_q << MUL_STEP;
        mplier_d = mplier_q >> MUL_STEP;
        cnt_d    = cnt_q - 1'b1;
        // Output register is guaranteed free here: MUL was only accepted when it would drain.
        if (cnt_q == CntW'(1)) begin
          state_d   = StIdle;
          valid_d   = 1'b1;
          result_d  = step_sum;
          zero_d    = (step_sum == '0);
          illegal_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush_i) begin
      state_d   = StIdle;
      valid_d   = 1'b0;
      illegal_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= StIdle;
      valid_q   <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
    end
  end

  assign valid_o   = valid_q;
  assign result_o  = result_q;
  assign zero_o    = zero_q;
  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: an 8-bit bit-serial instance and a 32-bit
// nibble-step instance, expected results queued at acceptance and popped on transfer out.
module tb_alu_exec_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       f8, v8, rdy8_i, ro8, vo8, z8, il8, bz8;
  logic [1:0] op8;
  logic [4:0] fn8;
  logic [7:0] a8, b8, r8;

  logic        f32, v32, rdy32_i, ro32, vo32, z32, il32, bz32;
  logic [1:0]  op32;
  logic [4:0]  fn32;
  logic [31:0] a32, b32, r32;

  typedef struct packed {
    logic [31:0] res;
    logic        ill;
  } exp_t;

  exp_t q8[$];
  exp_t q32[$];
  exp_t e8, e32;

  int n_cmp = 0;
  int n_bad = 0;

  alu_exec_unit #(.WIDTH(8), .MUL_STEP(1)) dut8 (
    .clk_i(clk), .rst_i(rst_n), .flush_i(f8), .valid_i(v8), .ready_o(ro8),
    .aluop_i(op8), .funct_i(fn8), .src1_i(a8), .src2_i(b8), .valid_o(vo8),
    .ready_i(rdy8_i), .result_o(r8), .zero_o(z8), .illegal_o(il8), .busy_o(bz8)
  );

  alu_exec_unit #(.WIDTH(32), .MUL_STEP(4)) dut32 (
    .clk_i(clk), .rst_i(rst_n), .flush_i(f32), .valid_i(v32), .ready_o(ro32),
    .aluop_i(op32), .funct_i(fn32), .src1_i(a32), .src2_i(b32), .valid_o(vo32),
    .ready_i(rdy32_i), .result_o(r32), .zero_o(z32), .illegal_o(il32), .busy_o(bz32)
  );

  always @(negedge clk) begin
    if (vo8 && rdy8_i) begin
      n_cmp++;
      if (q8.size() == 0) begin
        n_bad++;
        $display("FAIL sb8_unexpected: got result=%h ill=%b, required no output", r8, il8);
      end else begin
        e8 = q8.pop_front();
        if (r8 !== e8.res[7:0] || z8 !== (e8.res[7:0] == 8'h00) || il8 !== e8.ill) begin
          n_bad++;
          $display("FAIL sb8: got res=%h zero=%b ill=%b, required res=%h zero=%b ill=%b",
                   r8, z8, il8, e8.res[7:0], (e8.res[7:0] == 8'h00), e8.ill);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (vo32 && rdy32_i) begin
      n_cmp++;
      if (q32.size() == 0) begin
        n_bad++;
        $display("FAIL sb32_unexpected: got result=%h, required no output", r32);
      end else begin
        e32 = q32.pop_front();
        if (r32 !== e32.res || z32 !== (e32.res == 32'h0) || il32 !== e32.ill) begin
          n_bad++;
          $display("FAIL sb32: got res=%h zero=%b ill=%b, required res=%h zero=%b ill=%b",
                   r32, z32, il32, e32.res, (e32.res == 32'h0), e32.ill);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] model8(input logic [1:0] op, input logic [4:0] fn,
                                        input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic       il;
    r  = 8'h00;
    il = 1'b0;
    if (op == 2'b01) r = a - b;
    else if (op != 2'b10) r = a + b;
    else begin
      case (fn)
        5'b00000: r = a + b;
        5'b10000: r = a - b;
        5'b01000: r = a * b;
        5'b00111: r = a & b;
        5'b00110: r = a | b;
        5'b00100: r = a ^ b;
        5'b00001: r = a << b[2:0];
        5'b00101: r = a >> b[2:0];
        default:  il = 1'b1;
      endcase
    end
    return {il, r};
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send8(input logic [1:0] op, input logic [4:0] fn, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] er, input logic ei);
    int t = 0;
    op8 = op; fn8 = fn; a8 = a; b8 = b; v8 = 1'b1;
    @(negedge clk);
    while (!ro8 && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (t >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send8_timeout: ready_o stayed 0, required 1 within 50 cycles");
    end else begin
      q8.push_back('{res: 32'(er), ill: ei});
    end
    @(posedge clk); #1;
    v8 = 1'b0;
  endtask

  task automatic send32(input logic [1:0] op, input logic [4:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er);
    int t = 0;
    op32 = op; fn32 = fn; a32 = a; b32 = b; v32 = 1'b1;
    @(negedge clk);
    while (!ro32 && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (t >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send32_timeout: ready_o stayed 0, required 1 within 50 cycles");
    end else begin
      q32.push_back('{res: er, ill: 1'b0});
    end
    @(posedge clk); #1;
    v32 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({vo8, r8, z8, il8, bz8, ro8} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset8: got v=%b r=%h z=%b il=%b busy=%b rdy=%b, required 0 00 0 0 0 1",
               vo8, r8, z8, il8, bz8, ro8);
    end
    n_cmp++;
    if ({vo32, r32, z32, il32, bz32, ro32} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset32: got v=%b r=%h busy=%b rdy=%b, required 0 0 0 1",
               vo32, r32, bz32, ro32);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    send8(2'b10, 5'b10000, 8'd5, 8'd7, 8'hFE, 1'b0);
    n_cmp++;
    if (vo8 !== 1'b1 || r8 !== 8'hFE || z8 !== 1'b0) begin
      n_bad++;
      $display("FAIL sub_latency: got v=%b r=%h z=%b, required 1 fe 0", vo8, r8, z8);
    end
    send8(2'b01, 5'b00000, 8'h3C, 8'h3C, 8'h00, 1'b0);
    send8(2'b10, 5'b11111, 8'h12, 8'h34, 8'h00, 1'b1);
    n_cmp++;
    if (il8 !== 1'b1 || r8 !== 8'h00) begin
      n_bad++;
      $display("FAIL illegal: got il=%b r=%h, required 1 00", il8, r8);
    end
    send8(2'b00, 5'b11111, 8'hF0, 8'h20, 8'h10, 1'b0);
    send8(2'b11, 5'b01000, 8'h01, 8'hFF, 8'h00, 1'b0);
  endtask

  task automatic test_ops();
    logic [4:0] fns [8];
    logic [1:0] op;
    logic [4:0] fn;
    logic [7:0] a, b;
    logic [8:0] m;
    fns = '{5'b00000, 5'b10000, 5'b00111, 5'b00110, 5'b00100, 5'b00001, 5'b00101, 5'b01000};
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      fn = (i % 4 == 3) ? 5'($urandom_range(0, 31)) : fns[$urandom_range(0, 7)];
      a  = 8'($urandom);
      b  = 8'($urandom);
      m  = model8(op, fn, a, b);
      send8(op, fn, a, b, m[7:0], m[8]);
    end
  endtask

  task automatic test_mul();
    int cnt = 0;
    logic seen_early = 1'b0;
    logic rdy_busy = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    send8(2'b10, 5'b01000, 8'd13, 8'd11, 8'h8F, 1'b0);
    @(negedge clk);
    while (bz8 && cnt < 20) begin
      if (ro8) rdy_busy = 1'b1;
      if (vo8) seen_early = 1'b1;
      cnt++;
      @(negedge clk);
    end
    n_cmp++;
    if (cnt != 8) begin
      n_bad++;
      $display("FAIL mul_busy_cycles: got %0d, required 8", cnt);
    end
    n_cmp++;
    if (rdy_busy || seen_early) begin
      n_bad++;
      $display("FAIL mul_busy_flags: got ready_while_busy=%b early_valid=%b, required 0 0",
               rdy_busy, seen_early);
    end
    n_cmp++;
    if (vo8 !== 1'b1 || r8 !== 8'h8F) begin
      n_bad++;
      $display("FAIL mul_done: got v=%b r=%h, required 1 8f", vo8, r8);
    end
    @(posedge clk); #1;
    send8(2'b10, 5'b01000, 8'hFF, 8'hFF, 8'h01, 1'b0);
    send8(2'b00, 5'b00000, 8'h40, 8'h02, 8'h42, 1'b0);
  endtask

  task automatic test_back_to_back();
    time t0;
    repeat (12) @(posedge clk);
    #1;
    t0 = $time;
    send8(2'b11, 5'b00000, 8'h21, 8'h13, 8'h34, 1'b0);
    n_cmp++;
    if (r8 !== 8'h34) begin
      n_bad++;
      $display("FAIL b2b_add: got %h, required 34", r8);
    end
    send8(2'b10, 5'b00001, 8'h0B, 8'h0A, 8'h2C, 1'b0);
    n_cmp++;
    if (r8 !== 8'h2C || ($time - t0) != 20) begin
      n_bad++;
      $display("FAIL b2b_sll: got r=%h dt=%0t, required r=2c dt=20", r8, $time - t0);
    end
  endtask

  task automatic test_backpressure();
    logic bad = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rdy8_i = 1'b0;
    send8(2'b10, 5'b00110, 8'hA0, 8'h05, 8'hA5, 1'b0);
    op8 = 2'b00; a8 = 8'h01; b8 = 8'h01; v8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (vo8 !== 1'b1 || r8 !== 8'hA5 || z8 !== 1'b0 || ro8 !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_bad++;
      $display("FAIL backpressure_hold: got v=%b r=%h rdy=%b, required 1 a5 0", vo8, r8, ro8);
    end
    @(posedge clk); #1;
    v8 = 1'b0;
    rdy8_i = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    logic leak = 1'b0;
    send8(2'b10, 5'b01000, 8'd9, 8'd9, 8'd81, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    f8 = 1'b1;
    @(posedge clk); #1;
    f8 = 1'b0;
    q8.delete();
    n_cmp++;
    if (vo8 !== 1'b0 || bz8 !== 1'b0 || il8 !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_mul: got v=%b busy=%b il=%b, required 0 0 0", vo8, bz8, il8);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (vo8) leak = 1'b1;
    end
    n_cmp++;
    if (leak) begin
      n_bad++;
      $display("FAIL flush_leak: got valid_o=1 after flush, required 0");
    end
    @(posedge clk); #1;
    send8(2'b00, 5'b00000, 8'h07, 8'h08, 8'h0F, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rdy8_i = 1'b0;
    send8(2'b10, 5'b11000, 8'h01, 8'h02, 8'h00, 1'b1);
    f8 = 1'b1;
    @(posedge clk); #1;
    f8 = 1'b0;
    q8.delete();
    n_cmp++;
    if (vo8 !== 1'b0 || il8 !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_held: got v=%b il=%b, required 0 0", vo8, il8);
    end
    rdy8_i = 1'b1;
  endtask

  task automatic test_reset_mid_mul();
    send8(2'b10, 5'b01000, 8'd200, 8'd3, 8'd88, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    q8.delete();
    n_cmp++;
    if ({vo8, r8, z8, il8, bz8, ro8} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_mid_mul: got v=%b r=%h z=%b il=%b busy=%b rdy=%b, required 0 00 0 0 0 1",
               vo8, r8, z8, il8, bz8, ro8);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    send8(2'b00, 5'b00000, 8'h80, 8'h80, 8'h00, 1'b0);
  endtask

  task automatic test_wide();
    int cnt = 0;
    send32(2'b10, 5'b01000, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE);
    @(negedge clk);
    while (bz32 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    n_cmp++;
    if (cnt != 8 || vo32 !== 1'b1 || r32 !== 32'hFFFF_FFFE) begin
      n_bad++;
      $display("FAIL mul32: got cycles=%0d v=%b r=%h, required 8 1 fffffffe", cnt, vo32, r32);
    end
    @(posedge clk); #1;
    send32(2'b10, 5'b00101, 32'h8000_0000, 32'h21, 32'h4000_0000);
    send32(2'b00, 5'b00000, 32'hFFFF_FFFF, 32'h1, 32'h0);
    send32(2'b10, 5'b01000, 32'h0001_2345, 32'h0000_1000, 32'h1234_5000);
    send32(2'b10, 5'b00001, 32'h0000_0003, 32'h0000_003F, 32'h8000_0000);
  endtask

  initial begin
    f8 = 1'b0; v8 = 1'b0; rdy8_i = 1'b1; op8 = 2'b00; fn8 = 5'b0; a8 = 8'h0; b8 = 8'h0;
    f32 = 1'b0; v32 = 1'b0; rdy32_i = 1'b1; op32 = 2'b00; fn32 = 5'b0; a32 = '0; b32 = '0;
    rst_n = 1'b0;
    test_reset();
    test_basic();
    test_ops();
    test_mul();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid_mul();
    test_wide();
    repeat (20) @(posedge clk);
    #1;
    n_cmp++;
    if (q8.size() != 0 || q32.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d pending results, required 0/0", q8.size(), q32.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
